// File: rtl/regfile_scoreboard.sv
// 32-entry register file with a pending-write scoreboard for in-order issue.
// Optional macro WB_BYPASS_EN forwards write-back data and releases dependents in the write-back cycle.
module regfile_scoreboard #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] WbData,
  input  logic [4:0]   WbReg,
  input  logic         WbEn,
  input  logic [4:0]   RdAddr1,
  input  logic [4:0]   RdAddr2,
  input  logic         Rd1Use,
  input  logic         Rd2Use,
  output logic [N-1:0] RdData1,
  output logic [N-1:0] RdData2,
  input  logic         IssueValid,
  input  logic         IssueWr,
  input  logic [4:0]   IssueReg,
  output logic         Stall,
  output logic         WbErr
);

  logic [N-1:0] r_regs [32];
  logic [31:0]  r_pending;
  logic         r_wberr;

  logic [31:0]  w_wb_mask;
  logic [31:0]  w_eff_pend;
  logic [31:0]  w_pending_nxt;
  logic         w_accept;

  assign w_wb_mask = WbEn ? (32'd1 << WbReg) : '0;

`ifdef WB_BYPASS_EN
  assign w_eff_pend = r_pending & ~w_wb_mask;
  assign RdData1    = (WbEn && (WbReg == RdAddr1)) ? WbData : r_regs[RdAddr1];
  assign RdData2    = (WbEn && (WbReg == RdAddr2)) ? WbData : r_regs[RdAddr2];
`else
  assign w_eff_pend = r_pending;
  assign RdData1    = r_regs[RdAddr1];
  assign RdData2    = r_regs[RdAddr2];
`endif

  assign Stall = IssueValid & ((Rd1Use  & w_eff_pend[RdAddr1]) |
                               (Rd2Use  & w_eff_pend[RdAddr2]) |
                               (IssueWr & w_eff_pend[IssueReg]));

  assign w_accept = IssueValid & ~Stall;
  assign WbErr    = r_wberr;

  // Clear from write-back first, then set from issue, so a same-register collision stays pending.
  always_comb begin
    w_pending_nxt = r_pending & ~w_wb_mask;
    if (w_accept && IssueWr) begin
      w_pending_nxt[IssueReg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
      r_pending <= '0;
      r_wberr   <= 1'b0;
    end else begin
      if (WbEn) begin
        r_regs[WbReg] <= WbData;
        if (!r_pending[WbReg]) begin
          r_wberr <= 1'b1;
        end
      end
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized checks of regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;
  localparam int N = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] WbData;
  logic [4:0]   WbReg;
  logic         WbEn;
  logic [4:0]   RdAddr1, RdAddr2;
  logic         Rd1Use, Rd2Use;
  logic [N-1:0] RdData1, RdData2;
  logic         IssueValid, IssueWr;
  logic [4:0]   IssueReg;
  logic         Stall, WbErr;

  regfile_scoreboard #(.N(N)) dut (
    .clk(clk), .rst(rst), .WbData(WbData), .WbReg(WbReg), .WbEn(WbEn),
    .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .Rd1Use(Rd1Use), .Rd2Use(Rd2Use),
    .RdData1(RdData1), .RdData2(RdData2), .IssueValid(IssueValid),
    .IssueWr(IssueWr), .IssueReg(IssueReg), .Stall(Stall), .WbErr(WbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents, outstanding-write flags, sticky error.
  logic [N-1:0] m_regs [32];
  bit           m_pend [32];
  bit           m_err;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit busy(input logic [4:0] r);
    return m_pend[r] && !(BYP && WbEn && WbReg == r);
  endfunction

  function automatic bit exp_stall();
    return IssueValid && ((Rd1Use && busy(RdAddr1)) || (Rd2Use && busy(RdAddr2)) ||
                          (IssueWr && busy(IssueReg)));
  endfunction

  function automatic logic [N-1:0] exp_rd(input logic [4:0] a);
    return (BYP && WbEn && WbReg == a) ? WbData : m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    rst = 1'b0; WbEn = 1'b0; WbReg = '0; WbData = '0;
    RdAddr1 = '0; RdAddr2 = '0; Rd1Use = 1'b0; Rd2Use = 1'b0;
    IssueValid = 1'b0; IssueWr = 1'b0; IssueReg = '0;
  endtask

  task automatic settle();
    #1;
    check("stall", Stall, exp_stall());
    check("rd1", RdData1, exp_rd(RdAddr1));
    check("rd2", RdData2, exp_rd(RdAddr2));
    check("wberr", WbErr, m_err);
  endtask

  task automatic commit();
    bit acc;
    acc = IssueValid && !exp_stall();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (WbEn) begin
        if (!m_pend[WbReg]) m_err = 1'b1;
        m_regs[WbReg] = WbData;
        m_pend[WbReg] = 1'b0;
      end
      if (acc && IssueWr) m_pend[IssueReg] = 1'b1;
    end
    #1;
  endtask

  task automatic rand_inputs(input bit allow_rst);
    int unsigned k;
    bit found;
    idle();
    IssueValid = 1'($urandom_range(0, 1));
    IssueWr    = 1'($urandom_range(0, 1));
    IssueReg   = 5'($urandom);
    Rd1Use     = 1'($urandom_range(0, 1));
    Rd2Use     = 1'($urandom_range(0, 1));
    RdAddr1    = 5'($urandom);
    RdAddr2    = 5'($urandom);
    WbData     = N'($urandom);
    k = $urandom_range(0, 31);
    found = 1'b0;
    if ($urandom_range(0, 9) < 6) begin
      for (int j = 0; j < 32; j++) begin
        if (!found && m_pend[(k + j) % 32]) begin
          found = 1'b1;
          WbEn  = 1'b1;
          WbReg = 5'((k + j) % 32);
        end
      end
    end
    if ($urandom_range(0, 39) == 0) begin
      WbEn  = 1'b1;
      WbReg = 5'($urandom);
    end
    // Bias reads toward the write-back target to exercise same-cycle read/write.
    if (WbEn && $urandom_range(0, 2) == 0) RdAddr1 = WbReg;
    if (allow_rst) rst = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;

    // Reset state: every register reads zero.
    for (int a = 0; a < 16; a++) begin
      idle();
      RdAddr1 = 5'(a);
      RdAddr2 = 5'(a + 16);
      settle();
      check("rst_rd1", RdData1, '0);
      check("rst_rd2", RdData2, '0);
      check("rst_stall", Stall, '0);
      check("rst_wberr", WbErr, '0);
      commit();
    end

    // RAW hazard on register 5.
    idle(); IssueValid = 1'b1; IssueWr = 1'b1; IssueReg = 5'd5;
    settle(); check("iss5_stall", Stall, '0); commit();
    idle(); IssueValid = 1'b1; Rd1Use = 1'b1; RdAddr1 = 5'd5;
    settle(); check("raw_stall_a", Stall, 1); commit();
    settle(); check("raw_stall_b", Stall, 1); commit();
    WbEn = 1'b1; WbReg = 5'd5; WbData = 32'hDEADBEEF;
    settle();
`ifdef WB_BYPASS_EN
    check("byp_stall", Stall, '0);
    check("byp_rd1", RdData1, 32'hDEADBEEF);
`else
    check("nobyp_stall", Stall, 1);
    check("nobyp_rd1_old", RdData1, '0);
`endif
    commit();
    WbEn = 1'b0;
    settle();
    check("raw_done_stall", Stall, '0);
    check("raw_done_rd1", RdData1, 32'hDEADBEEF);
    commit();

    // WAW hazard and same-cycle set/clear on register 31.
    idle(); IssueValid = 1'b1; IssueWr = 1'b1; IssueReg = 5'd31;
    settle(); commit();
    settle(); check("waw_stall", Stall, 1); commit();
    WbEn = 1'b1; WbReg = 5'd31; WbData = 32'h0BAD_F00D;
    settle();
`ifdef WB_BYPASS_EN
    check("waw_wb_stall", Stall, '0);
`else
    check("waw_wb_stall", Stall, 1);
`endif
    commit();
    idle(); IssueValid = 1'b1; Rd1Use = 1'b1; RdAddr1 = 5'd31;
    settle();
`ifdef WB_BYPASS_EN
    check("pend31_kept", Stall, 1);
`else
    check("pend31_clear", Stall, '0);
`endif
    commit();

    // Write-back to a non-pending register sets the sticky error.
    idle(); WbEn = 1'b1; WbReg = 5'd7; WbData = 32'h1234_5678;
    settle(); check("err_before", WbErr, '0); commit();
    idle(); RdAddr2 = 5'd7;
    settle(); check("err_set", WbErr, 1); check("err_rd7", RdData2, 32'h1234_5678); commit();
    for (int c = 0; c < 20; c++) begin
      rand_inputs(1'b0);
      settle(); check("err_held", WbErr, 1); commit();
    end

    // Reset wins over a same-cycle write-back and drops pending state.
    idle(); rst = 1'b1; settle(); commit();
    idle(); IssueValid = 1'b1; IssueWr = 1'b1; IssueReg = 5'd3;
    settle(); commit();
    idle(); rst = 1'b1; WbEn = 1'b1; WbReg = 5'd3; WbData = 32'hCAFE_0003;
    settle(); commit();
    idle(); IssueValid = 1'b1; Rd1Use = 1'b1; RdAddr1 = 5'd3;
    settle();
    check("rst_mid_rd3", RdData1, '0);
    check("rst_mid_stall", Stall, '0);
    check("rst_mid_err", WbErr, '0);
    commit();
    idle(); WbEn = 1'b1; WbReg = 5'd3; WbData = 32'h3;
    settle(); commit();
    idle(); settle(); check("stale_wb_err", WbErr, 1); commit();

    // Randomized traffic against the model.
    idle(); rst = 1'b1; settle(); commit();
    for (int c = 0; c < 600; c++) begin
      rand_inputs(1'b1);
      settle();
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter N, default 32, register/data width in bits.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: WbData  in  N  write-back data from write-back stage.
REQ-005 SHALL have ports: WbReg  in  5  write-back destination register number.
REQ-006 SHALL have ports: WbEn  in  1  write-back valid this cycle.
REQ-007 SHALL have ports: RdAddr1, RdAddr2  in  5 each  decode source register numbers.
REQ-008 SHALL have ports: Rd1Use, Rd2Use  in  1 each  source actually read by issuing instruction.
REQ-009 SHALL have ports: RdData1, RdData2  out  N each  source operand data.
REQ-010 SHALL have ports: IssueValid  in  1  decode presents an instruction.
REQ-011 SHALL have ports: IssueWr  in  1  presented instruction writes a register.
REQ-012 SHALL have ports: IssueReg  in  5  its destination (Rx or link register, already muxed).
REQ-013 SHALL have ports: Stall  out  1  presented instruction may not issue this cycle.
REQ-014 SHALL have ports: WbErr  out  1  sticky: write-back to a register not pending.

Function
REQ-015 SHALL hold 32 N-bit registers, all writable, plus a 32-bit pending vector.
REQ-016 SHALL write WbData to register WbReg at the clock edge when WbEn=1; visible from next cycle.
REQ-017 SHALL read RdData1/RdData2 combinationally from the addressed registers (zero-cycle read latency).
REQ-018 SHALL compute Stall combinationally = IssueValid & ((Rd1Use & P[RdAddr1]) | (Rd2Use & P[RdAddr2]) | (IssueWr & P[IssueReg])), P = effective pending per REQ-027/028.
REQ-019 SHALL accept an issue when IssueValid=1 and Stall=0; no acceptance otherwise.
REQ-020 SHALL set pending[IssueReg] at the edge of an accepted issue with IssueWr=1.
REQ-021 SHALL clear pending[WbReg] at the edge when WbEn=1.
REQ-022 SHALL let set win when an accepted issue and WbEn target the same register in the same cycle (pending stays 1).
REQ-023 SHALL never have two outstanding writes to one register (guaranteed by WAW term of REQ-018).
REQ-024 SHALL set WbErr at the edge when WbEn=1 and pending[WbReg]=0; WbErr stays 1 until reset; the write still occurs.
REQ-025 SHALL allow write-back and a read of the same register in one cycle; data returned per Configuration.
REQ-026 SHALL ignore IssueReg/RdAddr values when the qualifying use/valid bit is 0.

Reset
REQ-029 SHALL on rst=1 at an edge clear all 32 registers to 0, pending to 0, WbErr to 0; rst has priority over WbEn and issue in that cycle.
REQ-030 SHALL output after reset: RdData1=RdData2=0, Stall=0, WbErr=0.
REQ-031 SHALL discard any in-flight pending state on reset mid-operation; a subsequent WbEn then sets WbErr.

Configuration
REQ-027 SHALL, with macro WB_BYPASS_EN defined: RdDataX = WbData when WbEn=1 and WbReg=RdAddrX; effective P[r] = pending[r] & ~(WbEn & WbReg==r), so dependents issue in the write-back cycle.
REQ-028 SHALL, without WB_BYPASS_EN: RdDataX returns the pre-write register value; effective P = pending, so dependents issue the cycle after write-back.

Verification
REQ-032 SHALL cover: reset, then read all 32 registers -> all 0, Stall=0, WbErr=0.
REQ-033 SHALL cover: issue IssueWr, IssueReg=5; next cycle IssueValid, Rd1Use, RdAddr1=5 -> Stall=1 until write-back of 0xDEADBEEF to reg 5; bypass: Stall=0 and RdData1=0xDEADBEEF in WbEn cycle; no bypass: Stall=0, RdData1=0xDEADBEEF one cycle later.
REQ-034 SHALL cover: reg 31 pending, issue with IssueWr, IssueReg=31 -> Stall=1 (WAW); same-cycle WbEn reg 31 plus accepted issue to 31 (bypass build) -> pending[31] remains 1.
REQ-035 SHALL cover: WbEn=1, WbReg=7 with pending[7]=0 -> reg 7 written, WbErr=1 and held through later traffic until rst.
REQ-036 SHALL cover: rst asserted with pending[3]=1 and WbEn=1 to reg 3 same cycle -> reg 3=0, pending cleared, Stall=0 for reads of 3.
